// File: rtl/window_buffer_3x3.sv
// -----------------------------------------------------------------------------
// window_buffer_3x3
//
// Streaming 3x3 neighbourhood generator. Pixels arrive in raster order, one per
// cycle in which in_valid is high, with no backpressure. Two line buffers hold
// the previous two rows. A 3x3 register window slides one column to the left on
// every accepted pixel. The window is flagged valid only when it lies fully
// inside the image.
//
// Parameters
//   IMG_W      pixels per line (>= 3), also the depth of each line buffer
//   IMG_H      lines per frame (>= 3)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   in_data carries a pixel this cycle
//   in_sof     qualified by in_valid: this pixel is (row 0, col 0) of a frame
//   in_data    6-bit two's-complement pixel
//   win_valid  one-cycle strobe: w0..w8 hold a complete in-image window
//   w0..w8     window taps, row-major. w0 is the top-left tap (r-2, c-2),
//              w4 is the centre tap and w8 is the current pixel (r, c)
//   frame_done one-cycle pulse after the last pixel of a frame is accepted
// -----------------------------------------------------------------------------
module window_buffer_3x3 #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [5:0] in_data,
  output logic       win_valid,
  output logic [5:0] w0,
  output logic [5:0] w1,
  output logic [5:0] w2,
  output logic [5:0] w3,
  output logic [5:0] w4,
  output logic [5:0] w5,
  output logic [5:0] w6,
  output logic [5:0] w7,
  output logic [5:0] w8,
  output logic       frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Raster position of the next pixel
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Position the pixel on in_data takes if it is accepted this cycle
  logic [CW-1:0] acc_col;
  logic [RW-1:0] acc_row;
  logic          accept;

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2, indexed by column
  logic [5:0] lb1_q [IMG_W];
  logic [5:0] lb1_d [IMG_W];
  logic [5:0] lb2_q [IMG_W];
  logic [5:0] lb2_d [IMG_W];
  logic [IMG_W-1:0] lb_we;
  logic [5:0] lb1_rd;
  logic [5:0] lb2_rd;

  // 3x3 window, index 0..8 in row-major order
  logic [5:0] win_q [9];
  logic [5:0] win_d [9];

  logic win_valid_q, win_valid_d;
  logic frame_done_q, frame_done_d;

  // ---------------------------------------------------------------------------
  // Position of the incoming pixel. A start-of-frame marker overrides the
  // counters so that a frame can be restarted at any point.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept  = in_valid;
    acc_col = in_sof ? '0 : col_q;
    acc_row = in_sof ? '0 : row_q;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (acc_col == COL_LAST) begin
        col_d = '0;
        row_d = (acc_row == ROW_LAST) ? '0 : acc_row + RW'(1);
      end else begin
        col_d = acc_col + CW'(1);
        row_d = acc_row;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers. Each column slot is written only when a pixel lands in that
  // column. The old row r-1 value moves down into the r-2 buffer as the new
  // pixel replaces it, so the buffers always describe the two rows above.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < IMG_W; gi++) begin : g_lb_we
      assign lb_we[gi] = accept && (acc_col == CW'(gi));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < IMG_W; i++) begin
      lb1_d[i] = lb_we[i] ? in_data  : lb1_q[i];
      lb2_d[i] = lb_we[i] ? lb1_q[i] : lb2_q[i];
    end
  end

  // Column read happens before the update, so the right-hand window column
  // is {row r-2, row r-1, row r} at the same column index.
  assign lb1_rd = lb1_q[acc_col];
  assign lb2_rd = lb2_q[acc_col];

  // ---------------------------------------------------------------------------
  // Window shift. Columns slide left and the new column enters on the right.
  // Stale data from the previous row or frame is never flushed. The valid
  // strobe is masked until two full rows and two columns have entered.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      win_d[i] = win_q[i];
    end
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb2_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = in_data;
    end
  end

  always_comb begin
    win_valid_d  = accept && (acc_row >= ROW_TWO) && (acc_col >= COL_TWO);
    frame_done_d = accept && (acc_row == ROW_LAST) && (acc_col == COL_LAST);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < IMG_W; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < IMG_W; i++) begin
        lb1_q[i] <= lb1_d[i];
        lb2_q[i] <= lb2_d[i];
      end
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign w0 = win_q[0];
  assign w1 = win_q[1];
  assign w2 = win_q[2];
  assign w3 = win_q[3];
  assign w4 = win_q[4];
  assign w5 = win_q[5];
  assign w6 = win_q[6];
  assign w7 = win_q[7];
  assign w8 = win_q[8];

endmodule

// File: tb/tb_window_buffer_3x3.sv
// -----------------------------------------------------------------------------
// tb_window_buffer_3x3
//
// Scoreboard bench for window_buffer_3x3. The stimulus side keeps a picture of
// the frame as a 2-D array and, for every accepted pixel whose 3x3
// neighbourhood fits inside the image, pushes the expected window into a
// queue. A negedge monitor pops and compares whenever win_valid is high. It
// also checks the reset state and the hold behaviour on idle cycles, and it
// counts windows and frame_done pulses for each scenario.
// -----------------------------------------------------------------------------
module tb_window_buffer_3x3;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [5:0] in_data = '0;
  logic       win_valid;
  logic [5:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic       frame_done;

  window_buffer_3x3 #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .win_valid  (win_valid),
    .w0         (w0),
    .w1         (w1),
    .w2         (w2),
    .w3         (w3),
    .w4         (w4),
    .w5         (w5),
    .w6         (w6),
    .w7         (w7),
    .w8         (w8),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [53:0] taps;
    bit          fd;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int win_cnt  = 0;
  int fd_cnt   = 0;

  // Reference picture of the current frame, indexed [row][col]
  logic [5:0] img [IMG_H][IMG_W];
  int mr = 0;
  int mc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mr = 0;
    mc = 0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = '0;
  endtask

  // Place the pixel in the picture and, if its neighbourhood is complete,
  // predict the window that should appear one cycle later.
  task automatic model_accept(input bit sof, input logic [5:0] d);
    int r;
    int c;
    exp_t e;
    r = sof ? 0 : mr;
    c = sof ? 0 : mc;
    img[r][c] = d;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 9; i++)
        e.taps[(8 - i) * 6 +: 6] = img[r - 2 + i / 3][c - 2 + i % 3];
      e.fd = (r == IMG_H - 1) && (c == IMG_W - 1);
      exp_q.push_back(e);
    end
    c = c + 1;
    if (c == IMG_W) begin
      c = 0;
      r = (r == IMG_H - 1) ? 0 : r + 1;
    end
    mr = r;
    mc = c;
  endtask

  task automatic send(input bit sof, input logic [5:0] d);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    model_accept(sof, d);
  endtask

  // Idle cycles carry random sof/data so that an unqualified sof is exercised
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'($urandom);
      in_data  = 6'($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sof   = 1'($urandom);
    in_data  = 6'($urandom);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // kind: 0 ramp c+4r-16, 1 all -32, 2 all 31, 3 random
  task automatic send_frame(input int kind, input bit gaps, input int npix);
    logic [5:0] d;
    for (int idx = 0; idx < npix; idx++) begin
      int r;
      int c;
      r = idx / IMG_W;
      c = idx % IMG_W;
      case (kind)
        0:       d = 6'(c + 4 * r - 16);
        1:       d = 6'b100000;
        2:       d = 6'd31;
        default: d = 6'($urandom);
      endcase
      send(idx == 0, d);
      if (gaps) idle($urandom_range(0, 3));
    end
  endtask

  task automatic end_scenario(input string name, input int exp_win, input int exp_fd);
    idle(4);
    check({name, "_windows"}, 64'(win_cnt), 64'(exp_win));
    check({name, "_frame_done"}, 64'(fd_cnt), 64'(exp_fd));
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    $display("scenario %s: %0d windows, %0d frame_done pulses", name, win_cnt, fd_cnt);
    exp_q.delete();
    win_cnt = 0;
    fd_cnt  = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor. Inputs are stable across the negedge, so the values seen here are
  // the ones sampled at the next posedge. They are saved to classify the next
  // sample.
  // ---------------------------------------------------------------------------
  logic [53:0] prev_taps = '0;
  logic        prev_rst  = 1'b1;
  logic        prev_acc  = 1'b0;

  always @(negedge clk) begin
    logic [53:0] cur;
    exp_t e;
    cur = {w0, w1, w2, w3, w4, w5, w6, w7, w8};
    if (prev_rst) begin
      check("reset_win_valid", 64'(win_valid), 64'd0);
      check("reset_frame_done", 64'(frame_done), 64'd0);
      check("reset_taps", 64'(cur), 64'd0);
    end else if (!prev_acc) begin
      check("idle_win_valid", 64'(win_valid), 64'd0);
      check("idle_frame_done", 64'(frame_done), 64'd0);
      check("idle_taps_held", 64'(cur), 64'(prev_taps));
    end else if (win_valid) begin
      win_cnt++;
      check("window_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("window_taps", 64'(cur), 64'(e.taps));
        check("window_frame_done", 64'(frame_done), 64'(e.fd));
        $display("window %0d: taps %0h frame_done %0b", win_cnt, cur, frame_done);
      end
    end else begin
      check("frame_done_without_window", 64'(frame_done), 64'd0);
    end
    if (frame_done) fd_cnt++;
    prev_taps = cur;
    prev_rst  = reset;
    prev_acc  = in_valid;
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // 1: ramp frame, no gaps
    send_frame(0, 1'b0, IMG_W * IMG_H);
    end_scenario("ramp", 36, 1);

    // 2: same frame with random idle gaps
    send_frame(0, 1'b1, IMG_W * IMG_H);
    end_scenario("ramp_gaps", 36, 1);

    // 3: reset at pixel (3,4), then a fresh frame. The 8 windows before the
    // reset come from pixels already accepted.
    send_frame(0, 1'b0, 3 * IMG_W + 4);
    do_reset();
    send_frame(0, 1'b0, IMG_W * IMG_H);
    end_scenario("reset_mid", 8 + 36, 1);

    // 4: sof at pixel (4,5) restarts with a full frame
    send_frame(3, 1'b0, 4 * IMG_W + 5);
    send_frame(0, 1'b0, IMG_W * IMG_H);
    end_scenario("sof_mid", 15 + 36, 1);

    // 5: extreme values back to back
    send_frame(1, 1'b0, IMG_W * IMG_H);
    send_frame(2, 1'b0, IMG_W * IMG_H);
    end_scenario("extremes", 72, 2);

    // 6: two random frames back to back
    send_frame(3, 1'b0, IMG_W * IMG_H);
    send_frame(3, 1'b0, IMG_W * IMG_H);
    end_scenario("two_frames", 72, 2);

    // 7: random frame with gaps
    send_frame(3, 1'b1, IMG_W * IMG_H);
    end_scenario("random_gaps", 36, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
